// File: rtl/mprc_metadata_array_gen_if.sv
// rtl/mprc_metadata_array_gen_if.sv - request/response bundle of the cache metadata array
interface mprc_metadata_array_gen_if #(
  parameter int SETS  = 64,
  parameter int WAYS  = 4,
  parameter int TAG_W = 20,
  parameter int COH_W = 2
);
  localparam int IDX_W = $clog2(SETS);

  logic                   init_req;
  logic                   io_init_busy;
  logic                   io_write_valid;
  logic                   io_write_ready;
  logic [IDX_W-1:0]       io_write_bits_idx;
  logic [WAYS-1:0]        io_write_bits_way_en;
  logic [TAG_W-1:0]       io_write_bits_data_tag;
  logic [COH_W-1:0]       io_write_bits_data_coh_state;
  logic                   io_read_valid;
  logic                   io_read_ready;
  logic [IDX_W-1:0]       io_read_bits_idx;
  logic [TAG_W-1:0]       io_read_bits_tag;
  logic                   io_resp_valid;
  logic [WAYS*TAG_W-1:0]  io_resp_tag;
  logic [WAYS*COH_W-1:0]  io_resp_coh_state;
  logic [WAYS-1:0]        io_resp_hit;
  logic                   io_resp_multi_hit;

  modport master (
    output init_req, io_write_valid, io_write_bits_idx, io_write_bits_way_en,
           io_write_bits_data_tag, io_write_bits_data_coh_state,
           io_read_valid, io_read_bits_idx, io_read_bits_tag,
    input  io_init_busy, io_write_ready, io_read_ready, io_resp_valid,
           io_resp_tag, io_resp_coh_state, io_resp_hit, io_resp_multi_hit
  );

  modport slave (
    input  init_req, io_write_valid, io_write_bits_idx, io_write_bits_way_en,
           io_write_bits_data_tag, io_write_bits_data_coh_state,
           io_read_valid, io_read_bits_idx, io_read_bits_tag,
    output io_init_busy, io_write_ready, io_read_ready, io_resp_valid,
           io_resp_tag, io_resp_coh_state, io_resp_hit, io_resp_multi_hit
  );
endinterface

// File: rtl/mprc_metadata_array_gen.sv
// rtl/mprc_metadata_array_gen.sv - tag/coherence metadata array with clear sweep and write-to-response bypass
module mprc_metadata_array_gen #(
  parameter int SETS    = 64,
  parameter int WAYS    = 4,
  parameter int TAG_W   = 20,
  parameter int COH_W   = 2,
  parameter int RST_COH = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  mprc_metadata_array_gen_if.slave meta_io
);
  localparam int IDX_W = $clog2(SETS);
  localparam logic [IDX_W:0]   SETS_C  = (IDX_W+1)'(SETS);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
  localparam logic [COH_W-1:0] RST_C   = COH_W'(RST_COH);
  localparam logic [WAYS-1:0]  WAY_ONE = WAYS'(1);

  logic [TAG_W-1:0] tag_mem_q [SETS][WAYS];
  logic [COH_W-1:0] coh_mem_q [SETS][WAYS];

  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0] resp_tag_q [WAYS];
  logic [TAG_W-1:0] resp_tag_d [WAYS];
  logic [COH_W-1:0] resp_coh_q [WAYS];
  logic [COH_W-1:0] resp_coh_d [WAYS];
  logic [IDX_W-1:0] resp_idx_q, resp_idx_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             held_q, held_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WAYS-1:0]  hit_q, hit_d;
  logic             multi_q, multi_d;

  logic busy, write_fire, read_fire;

  assign busy       = cnt_q < SETS_C;
  assign write_fire = meta_io.io_write_valid & ~busy;
  assign read_fire  = meta_io.io_read_valid & ~busy & ~meta_io.io_write_valid;

  always_comb begin
    cnt_d = cnt_q;
    if (meta_io.init_req) cnt_d = '0;
    else if (busy)        cnt_d = cnt_q + CNT_ONE;
  end

  // Response registers: a new read loads a whole set; otherwise a write to the
  // held set is merged way-by-way so s1 never sees stale metadata.
  always_comb begin
    resp_tag_d   = resp_tag_q;
    resp_coh_d   = resp_coh_q;
    resp_idx_d   = resp_idx_q;
    rtag_d       = rtag_q;
    held_d       = held_q;
    resp_valid_d = read_fire;
    if (read_fire) begin
      resp_idx_d = meta_io.io_read_bits_idx;
      rtag_d     = meta_io.io_read_bits_tag;
      held_d     = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        resp_tag_d[w] = tag_mem_q[meta_io.io_read_bits_idx][w];
        resp_coh_d[w] = coh_mem_q[meta_io.io_read_bits_idx][w];
      end
    end else if (write_fire && held_q && (meta_io.io_write_bits_idx == resp_idx_q)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (meta_io.io_write_bits_way_en[w]) begin
          resp_tag_d[w] = meta_io.io_write_bits_data_tag;
          resp_coh_d[w] = meta_io.io_write_bits_data_coh_state;
        end
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      hit_d[w] = (resp_tag_d[w] == rtag_d) && (resp_coh_d[w] != '0);
    end
    multi_d = |(hit_d & (hit_d - WAY_ONE));
    if (meta_io.init_req) begin
      resp_valid_d = 1'b0;
      hit_d        = '0;
      multi_d      = 1'b0;
      held_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      resp_tag_q   <= '{default: '0};
      resp_coh_q   <= '{default: '0};
      resp_idx_q   <= '0;
      rtag_q       <= '0;
      held_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      hit_q        <= '0;
      multi_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      resp_tag_q   <= resp_tag_d;
      resp_coh_q   <= resp_coh_d;
      resp_idx_q   <= resp_idx_d;
      rtag_q       <= rtag_d;
      held_q       <= held_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      multi_q      <= multi_d;
    end
  end

  // Storage carries no reset; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (busy) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_mem_q[cnt_q[IDX_W-1:0]][w] <= '0;
          coh_mem_q[cnt_q[IDX_W-1:0]][w] <= RST_C;
        end
      end else if (write_fire) begin
        for (int w = 0; w < WAYS; w++) begin
          if (meta_io.io_write_bits_way_en[w]) begin
            tag_mem_q[meta_io.io_write_bits_idx][w] <= meta_io.io_write_bits_data_tag;
            coh_mem_q[meta_io.io_write_bits_idx][w] <= meta_io.io_write_bits_data_coh_state;
          end
        end
      end
    end
  end

  assign meta_io.io_init_busy      = busy;
  assign meta_io.io_write_ready    = ~busy;
  assign meta_io.io_read_ready     = ~busy & ~meta_io.io_write_valid;
  assign meta_io.io_resp_valid     = resp_valid_q;
  assign meta_io.io_resp_hit       = hit_q;
  assign meta_io.io_resp_multi_hit = multi_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_flat
    assign meta_io.io_resp_tag[w*TAG_W +: TAG_W]       = resp_tag_q[w];
    assign meta_io.io_resp_coh_state[w*COH_W +: COH_W] = resp_coh_q[w];
  end
endmodule

// File: tb/tb_mprc_metadata_array_gen.sv
// tb/tb_mprc_metadata_array_gen.sv - random and directed checks of the metadata array against a set/way model
module tb_mprc_metadata_array_gen;
  localparam int SETS  = 64;
  localparam int WAYS  = 4;
  localparam int TAG_W = 20;
  localparam int COH_W = 2;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mprc_metadata_array_gen_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .COH_W(COH_W)) mif ();

  mprc_metadata_array_gen #(
    .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .COH_W(COH_W), .RST_COH(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .meta_io(mif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: contents per set/way, sweep position, and the response the cache should see.
  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  logic [COH_W-1:0] m_coh [SETS][WAYS];
  int               sweep;
  logic             e_valid;
  logic [TAG_W-1:0] e_tag [WAYS];
  logic [COH_W-1:0] e_coh [WAYS];
  logic [TAG_W-1:0] e_rtag;
  int               e_idx;
  bit               held;
  logic [WAYS-1:0]  e_hit;
  logic             e_multi;

  task automatic model_edge();
    bit busy, wacc, racc;
    int widx;
    if (!reset) begin
      sweep = 0; e_valid = 0; held = 0; e_rtag = '0; e_idx = 0; e_hit = '0; e_multi = 0;
      for (int w = 0; w < WAYS; w++) begin e_tag[w] = '0; e_coh[w] = '0; end
      return;
    end
    busy = sweep < SETS;
    wacc = mif.io_write_valid && !busy;
    racc = mif.io_read_valid && !busy && !mif.io_write_valid;
    widx = int'(mif.io_write_bits_idx);
    e_valid = racc;
    if (racc) begin
      e_idx  = int'(mif.io_read_bits_idx);
      e_rtag = mif.io_read_bits_tag;
      held   = 1;
      for (int w = 0; w < WAYS; w++) begin
        e_tag[w] = m_tag[e_idx][w];
        e_coh[w] = m_coh[e_idx][w];
      end
    end else if (wacc && held && widx == e_idx) begin
      for (int w = 0; w < WAYS; w++)
        if (mif.io_write_bits_way_en[w]) begin
          e_tag[w] = mif.io_write_bits_data_tag;
          e_coh[w] = mif.io_write_bits_data_coh_state;
        end
    end
    if (busy) begin
      for (int w = 0; w < WAYS; w++) begin m_tag[sweep][w] = '0; m_coh[sweep][w] = '0; end
    end else if (wacc) begin
      for (int w = 0; w < WAYS; w++)
        if (mif.io_write_bits_way_en[w]) begin
          m_tag[widx][w] = mif.io_write_bits_data_tag;
          m_coh[widx][w] = mif.io_write_bits_data_coh_state;
        end
    end
    if (mif.init_req) sweep = 0;
    else if (busy)    sweep = sweep + 1;
    for (int w = 0; w < WAYS; w++) e_hit[w] = (e_tag[w] == e_rtag) && (e_coh[w] != 0);
    e_multi = $countones(e_hit) > 1;
    if (mif.init_req) begin e_valid = 0; e_hit = '0; e_multi = 0; held = 0; end
  endtask

  task automatic check_outputs();
    logic [WAYS*TAG_W-1:0] et;
    logic [WAYS*COH_W-1:0] ec;
    bit busy;
    busy = sweep < SETS;
    for (int w = 0; w < WAYS; w++) begin
      et[w*TAG_W +: TAG_W] = e_tag[w];
      ec[w*COH_W +: COH_W] = e_coh[w];
    end
    chk("busy",       mif.io_init_busy, busy);
    chk("wready",     mif.io_write_ready, !busy);
    chk("rready",     mif.io_read_ready, !busy && !mif.io_write_valid);
    chk("resp_valid", mif.io_resp_valid, e_valid);
    chk("resp_tag",   mif.io_resp_tag, et);
    chk("resp_coh",   mif.io_resp_coh_state, ec);
    chk("resp_hit",   mif.io_resp_hit, e_hit);
    chk("multi_hit",  mif.io_resp_multi_hit, e_multi);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    mif.init_req = 0;
    mif.io_write_valid = 0; mif.io_write_bits_idx = '0; mif.io_write_bits_way_en = '0;
    mif.io_write_bits_data_tag = '0; mif.io_write_bits_data_coh_state = '0;
    mif.io_read_valid = 0; mif.io_read_bits_idx = '0; mif.io_read_bits_tag = '0;
  endtask

  task automatic set_write(int idx, logic [WAYS-1:0] en, logic [TAG_W-1:0] tag, logic [COH_W-1:0] coh);
    mif.io_write_valid = 1;
    mif.io_write_bits_idx = IDX_W'(idx);
    mif.io_write_bits_way_en = en;
    mif.io_write_bits_data_tag = tag;
    mif.io_write_bits_data_coh_state = coh;
  endtask

  task automatic set_read(int idx, logic [TAG_W-1:0] tag);
    mif.io_read_valid = 1;
    mif.io_read_bits_idx = IDX_W'(idx);
    mif.io_read_bits_tag = tag;
  endtask

  task automatic count_busy(string tag);
    int n = 0;
    while (mif.io_init_busy === 1'b1 && n < 200) begin step(); n++; end
    chk(tag, n, 64);
  endtask

  logic [TAG_W-1:0] tag_pool [4];

  initial begin
    tag_pool[0] = 20'h00000; tag_pool[1] = 20'h00001;
    tag_pool[2] = 20'hABCDE; tag_pool[3] = 20'hFFFFF;
    idle();
    reset = 0;
    repeat (3) step();
    reset = 1;
    count_busy("reset_sweep_len");

    for (int i = 0; i < SETS; i++) begin
      set_read(i, '0);
      step();
    end
    idle();
    step();

    set_write(5, 4'b0101, 20'hABCDE, 2'd3);
    step();
    idle();
    set_read(5, 20'hABCDE);
    step();
    idle();
    chk("t2_hit", mif.io_resp_hit, 4'b0101);
    chk("t2_multi", mif.io_resp_multi_hit, 1'b1);
    chk("t2_way2_tag", mif.io_resp_tag[2*TAG_W +: TAG_W], 20'hABCDE);
    chk("t2_way1_tag", mif.io_resp_tag[1*TAG_W +: TAG_W], 20'h0);

    set_read(9, 20'h12345);
    step();
    idle();
    set_write(9, 4'b0010, 20'h12345, 2'd1);
    step();
    idle();
    chk("t3_bypass_hit", mif.io_resp_hit, 4'b0010);
    chk("t3_bypass_tag", mif.io_resp_tag[1*TAG_W +: TAG_W], 20'h12345);

    set_write(3, 4'b1111, 20'h00055, 2'd2);
    set_read(3, 20'h00055);
    step();
    chk("t4_no_read", mif.io_resp_valid, 1'b0);
    mif.io_write_valid = 0;
    step();
    idle();
    chk("t4_read_late", mif.io_resp_valid, 1'b1);
    chk("t4_hit", mif.io_resp_hit, 4'b1111);

    set_write(7, 4'b1111, 20'h11111, 2'd2);
    step();
    idle();
    set_read(7, 20'h11111);
    mif.init_req = 1;
    step();
    idle();
    chk("t5_valid_clr", mif.io_resp_valid, 1'b0);
    chk("t5_hit_clr", mif.io_resp_hit, 4'b0000);
    count_busy("init_sweep_len");
    set_read(7, 20'h11111);
    step();
    idle();
    chk("t5_cleared_tag", mif.io_resp_tag, '0);
    chk("t5_cleared_hit", mif.io_resp_hit, 4'b0000);

    mif.init_req = 1;
    step();
    mif.init_req = 0;
    repeat (30) step();
    reset = 0;
    step();
    reset = 1;
    count_busy("reset_mid_sweep_len");

    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0)
        set_write($urandom_range(0, 7), WAYS'($urandom), tag_pool[$urandom_range(0, 3)],
                  COH_W'($urandom));
      if ($urandom_range(0, 1) != 0) set_read($urandom_range(0, 7), tag_pool[$urandom_range(0, 3)]);
      if ($urandom_range(0, 2) == 0) mif.io_write_valid = 0;
      mif.init_req = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 499) != 0);
      step();
    end
    reset = 1;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mprc_metadata_array_gen.md
Name: mprc_metadata_array_gen

Overview:
Parametrised tag/coherence metadata store for the non-blocking data cache: SETS x WAYS entries of {tag, coh_state}. It runs a hardware clear sweep after reset and on request. It accepts masked per-way writes and registered reads with write-to-read bypass. It returns per-way metadata plus a tag-hit vector for the cache pipeline's s1 stage.

Parameters:
SETS, 64, number of sets; power of two, >=2; IDX_W = clog2(SETS)
WAYS, 4, number of ways, 1..16
TAG_W, 20, tag width
COH_W, 2, coherence state width; state 0 = invalid
RST_COH, 0, coh value written by clear sweep (tag cleared to 0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
init_req  in  1  pulse: start a clear sweep
io_init_busy  out  1  clear sweep in progress
io_write_valid  in  1  write request
io_write_ready  out  1  write accepted when valid&ready
io_write_bits_idx  in  IDX_W  write set
io_write_bits_way_en  in  WAYS  per-way write mask
io_write_bits_data_tag  in  TAG_W  tag to write
io_write_bits_data_coh_state  in  COH_W  coh state to write
io_read_valid  in  1  read request
io_read_ready  out  1  read accepted when valid&ready
io_read_bits_idx  in  IDX_W  read set
io_read_bits_tag  in  TAG_W  tag to match
io_resp_valid  out  1  response valid
io_resp_tag  out  WAYS*TAG_W  way w at [w*TAG_W +: TAG_W]
io_resp_coh_state  out  WAYS*COH_W  way w at [w*COH_W +: COH_W]
io_resp_hit  out  WAYS  way w: tag equal and coh != 0
io_resp_multi_hit  out  1  more than one io_resp_hit bit set

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clk, reset port is reset, sampled on the rising clk edge while 0.
- Reset values: sweep counter = 0 and io_init_busy = 1. io_resp_valid, io_resp_tag, io_resp_coh_state, io_resp_hit and io_resp_multi_hit are all 0. Array contents are undefined until the sweep finishes.
- Clear sweep: counter is IDX_W+1 bits. While counter < SETS, busy = 1. Each cycle writes all ways of set[counter] with tag 0 and coh RST_COH, then increments. Busy drops after exactly SETS cycles.
- init_req=1 when not busy starts a new sweep from 0 on the next cycle. init_req during a sweep restarts the counter at 0.
- Starting a sweep (reset or init_req) clears io_resp_valid, io_resp_hit and io_resp_multi_hit.
- io_write_ready = ~busy. Writes presented while busy are not performed; the requester holds them.
- Accepted write: for each way w with way_en[w]=1, entry[idx][w] <= {tag, coh}. Other ways are unchanged. way_en = 0 is a no-op.
- io_read_ready = ~busy & ~io_write_valid. Writes have priority, and a read is never accepted in a cycle with write_valid.
- Accepted read in cycle N: at cycle N+1, io_resp_valid = 1 and outputs carry entry[idx] for all ways. io_resp_hit and io_resp_multi_hit are computed from the registered data and the registered io_read_bits_tag.
- Response outputs hold until the next accepted read or a sweep start. io_resp_valid falls to 0 in the cycle after a cycle with no accepted read.
- Bypass: if a write is accepted in cycle N+1 to the same idx as the currently held response, masked ways in the response registers update to the written data in the same edge. io_resp_hit and io_resp_multi_hit are recomputed accordingly. Unmasked ways keep their values.
- Reset asserted mid-sweep or mid-read: everything returns to reset values and the sweep restarts from 0.
- Bit slicing is exact: no truncation, and idx is used as an unsigned IDX_W-bit value.

Test Plan:
- Release reset with SETS=64: io_init_busy=1 for exactly 64 cycles and write/read ready=0. Then read idx 0..63: all tags 0, coh 0, hit=0000, resp_valid one cycle after each accept.
- Write idx 5, way_en 0101, tag 0xABCDE, coh 3, then read idx 5 with tag 0xABCDE: ways 0 and 2 return {0xABCDE,3}, ways 1 and 3 return {0,0}, hit=0101, multi_hit=1.
- Read idx 9, then write idx 9, way_en 0010, tag 0x12345, coh 1 the next cycle: response way 1 updates to {0x12345,1} at that edge. With read tag 0x12345, hit becomes 0010.
- Drive write_valid and read_valid together: read_ready=0, write is performed, read is accepted the cycle after write_valid drops.
- Write idx 7 tag 0x11111 coh 2, then pulse init_req: busy for 64 cycles, resp_valid cleared, later read idx 7 returns all zeros.
- Assert reset at cycle 30 of a sweep for 1 cycle: sweep restarts at 0 and busy lasts 64 more cycles.
